sfu_feeder: RTL and testbench
=============================

Name: sfu_feeder

Overview:
- Sequencer sitting between the OFIFO and the SFU.
- Pops `num_acc` partial-sum words per output pixel from the OFIFO and streams them into the SFU with `acc` held high.
- Drops `acc` for exactly one cycle to trigger the SFU's ReLU/clear, then captures the SFU result and writes it to output psum memory.
- Repeats for `num_out` pixels, then pulses `done`.

Parameters:
- `psum_bw`, 16, bits per psum lane
- `col`, 8, lanes (output channels) per word
- `num_acc`, 9, psum words accumulated per output pixel (kernel taps x input tiles); must be >= 1
- `num_out`, 16, output pixels per run
- `addr_bw`, 4, output memory address width; 2^`addr_bw` >= `num_out`

Ports:
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: begin a run; sampled only in IDLE
- `ofifo_valid` in 1: OFIFO has a word at its head
- `ofifo_out` in `psum_bw*col`: OFIFO head data
- `ofifo_rd` out 1: pop OFIFO this cycle (combinational)
- `acc` out 1: SFU accumulate enable (registered)
- `psum_out` out `psum_bw*col`: data to SFU `psum_in` (registered)
- `sfp_in` in `psum_bw*col`: SFU `sfp_out`
- `pmem_wr` out 1: output memory write strobe (registered)
- `pmem_addr` out `addr_bw`: write address (registered)
- `pmem_din` out `psum_bw*col`: write data (registered)
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle pulse at end of run

Behaviour:
- Reset (asserted low, async): state = IDLE; tap_cnt = 0, out_idx = 0; `acc`, `pmem_wr`, `done` = 0; `psum_out`, `pmem_addr`, `pmem_din` = 0. Reset mid-run abandons the run; no further pops or writes.
- States: IDLE, ACC, RELU, CAPTURE, DONE.
- IDLE
  - `acc` = 0.
  - `start` = 1 -> ACC; tap_cnt = 0, out_idx = 0.
  - `start` is ignored in all other states.
- ACC
  - `ofifo_rd` = `ofifo_valid`.
  - On pop: `psum_out` <= `ofifo_out`, `acc` <= 1, tap_cnt++.
  - Bubble (`ofifo_valid` = 0): `acc` <= 1, `psum_out` <= 0, so the SFU adds zero. `acc` must never drop mid-pixel; doing so would fire ReLU and clear the partial sum.
  - Pop with tap_cnt == `num_acc`-1 -> RELU.
- RELU (one cycle)
  - `ofifo_rd` = 0; `acc` <= 0, `psum_out` <= 0.
  - The final tap is added by the SFU at the end of this cycle.
  - -> CAPTURE.
- CAPTURE (two cycles, sub-phase bit)
  - Phase 0: `acc` = 0 is on the wire; the SFU registers ReLU(sum) at the end of the cycle.
  - Phase 1: `sfp_in` is valid for this cycle only. Later `acc` = 0 cycles reload the SFU output with ReLU(0) = 0, so capture must happen exactly here: `pmem_din` <= `sfp_in`, `pmem_addr` <= out_idx, `pmem_wr` <= 1.
  - Then: if out_idx == `num_out`-1 -> DONE, else out_idx++, tap_cnt = 0 -> ACC.
- DONE: `done` <= 1 for one cycle -> IDLE.
- Timing: `pmem_wr` is high one cycle per pixel, exactly 3 cycles after the final pop's edge (the cycle after CAPTURE phase 1). Pops resume no earlier than the cycle `pmem_wr` is high.
- `acc` pattern per pixel: high for (`num_acc` + bubbles) cycles, then low for at least 2 cycles.
- Arithmetic: no math here; accumulation overflow wraps inside the SFU. Data passes lane-for-lane, bit-exact.
- `num_acc` = 1: ACC lasts for exactly one pop.

Optional Feature:
- Macro `SFU_FEEDER_STALL_CNT_EN`.
- Defined: adds output `stall_cnt` [15:0], a registered count of ACC bubble cycles in the current run.
  - Cleared on reset and on the `start` accept.
  - Saturates at 16'hFFFF.
  - Holds its value after `done`.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- `num_acc` = 3, `num_out` = 2, `ofifo_valid` always 1, lane0 words 5, -2, 4 then -7, 1, 2 (other lanes 0) -> two `pmem_wr` pulses: addr 0 lane0 = 7, addr 1 lane0 = 0 (ReLU of -4); `done` one cycle after the last write.
- Same data with `ofifo_valid` low for 2 cycles between taps 1 and 2 -> `acc` stays high through the gap with `psum_out` = 0; results unchanged; `stall_cnt` = 2 when the macro is defined.
- `start` pulsed again while `busy` -> ignored; exactly `num_out` writes, addresses 0..`num_out`-1 in order.
- Reset driven low during ACC of pixel 1 -> all outputs 0 immediately (async); no `pmem_wr`; the next `start` runs cleanly from addr 0.
- `num_acc` = 1, all 8 lanes = 16'h7FFF -> `pmem_din` = 8 x 16'h7FFF; `acc` high exactly 1 cycle per pixel.
- Lanes mixed signs {-1, 1, -32768, 32767, 0, 2, -3, 4}, `num_acc` = 1 -> `pmem_din` {0, 1, 0, 32767, 0, 2, 0, 4}.

Source files
------------

// File: rtl/sfu_feeder.sv
// -----------------------------------------------------------------------------
// sfu_feeder
//
// Sequencer between the OFIFO and the SFU. For each output pixel it pops
// num_acc partial-sum words from the OFIFO and streams them into the SFU with
// acc held high. It then drops acc so the SFU applies ReLU and clears, captures
// the SFU result in the single cycle it is valid, and writes it to output psum
// memory. After num_out pixels it pulses done.
//
// Optional feature (compile-time macro SFU_FEEDER_STALL_CNT_EN):
//   adds output stall_cnt[15:0], a saturating count of ACC bubble cycles
//   in the current run. Without the macro the port and counter are absent.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   start        in   begin a run (sampled only in IDLE)
//   ofifo_valid  in   OFIFO head word present
//   ofifo_out    in   OFIFO head data, psum_bw*col bits
//   ofifo_rd     out  pop the OFIFO this cycle (combinational)
//   acc          out  SFU accumulate enable (registered)
//   psum_out     out  data to SFU psum_in (registered)
//   sfp_in       in   SFU sfp_out
//   pmem_wr      out  output memory write strobe (registered)
//   pmem_addr    out  output memory write address (registered)
//   pmem_din     out  output memory write data (registered)
//   busy         out  high in any state other than IDLE
//   done         out  one-cycle pulse at the end of a run
//   stall_cnt    out  bubble cycle count (only with SFU_FEEDER_STALL_CNT_EN)
// -----------------------------------------------------------------------------
module sfu_feeder #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int num_acc = 9,
  parameter int num_out = 16,
  parameter int addr_bw = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     ofifo_valid,
  input  logic [psum_bw*col-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic                     acc,
  output logic [psum_bw*col-1:0]   psum_out,
  input  logic [psum_bw*col-1:0]   sfp_in,
  output logic                     pmem_wr,
  output logic [addr_bw-1:0]       pmem_addr,
  output logic [psum_bw*col-1:0]   pmem_din,
  output logic                     busy,
  output logic                     done
`ifdef SFU_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int W     = psum_bw * col;
  localparam int TAP_W = (num_acc > 1) ? $clog2(num_acc) : 1;

  localparam logic [TAP_W-1:0]   TAP_LAST = TAP_W'(num_acc - 32'd1);
  localparam logic [TAP_W-1:0]   TAP_ONE  = TAP_W'(32'd1);
  localparam logic [TAP_W-1:0]   TAP_ZERO = TAP_W'(32'd0);
  localparam logic [addr_bw-1:0] OUT_LAST = addr_bw'(num_out - 32'd1);
  localparam logic [addr_bw-1:0] OUT_ONE  = addr_bw'(32'd1);
  localparam logic [addr_bw-1:0] OUT_ZERO = addr_bw'(32'd0);
  localparam logic [W-1:0]       W_ZERO   = {W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACC     = 3'd1,
    ST_RELU    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [TAP_W-1:0]     tap_cnt_r;
  logic [TAP_W-1:0]     tap_cnt_s;
  logic [addr_bw-1:0]   out_idx_r;
  logic [addr_bw-1:0]   out_idx_s;
  logic                 phase_r;
  logic                 phase_s;
  logic                 acc_s;
  logic [W-1:0]         psum_s;
  logic                 pmem_wr_s;
  logic [addr_bw-1:0]   pmem_addr_s;
  logic [W-1:0]         pmem_din_s;
  logic                 done_s;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      tap_cnt_r <= TAP_ZERO;
      out_idx_r <= OUT_ZERO;
      phase_r   <= 1'b0;
      acc       <= 1'b0;
      psum_out  <= W_ZERO;
      pmem_wr   <= 1'b0;
      pmem_addr <= OUT_ZERO;
      pmem_din  <= W_ZERO;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      tap_cnt_r <= tap_cnt_s;
      out_idx_r <= out_idx_s;
      phase_r   <= phase_s;
      acc       <= acc_s;
      psum_out  <= psum_s;
      pmem_wr   <= pmem_wr_s;
      pmem_addr <= pmem_addr_s;
      pmem_din  <= pmem_din_s;
      done      <= done_s;
    end
  end

  // Next-state and next-output logic for the pixel sequencer.
  always_comb begin
    state_s     = state_r;
    tap_cnt_s   = tap_cnt_r;
    out_idx_s   = out_idx_r;
    phase_s     = phase_r;
    acc_s       = 1'b0;
    psum_s      = W_ZERO;
    pmem_wr_s   = 1'b0;
    pmem_addr_s = pmem_addr;
    pmem_din_s  = pmem_din;
    done_s      = 1'b0;
    ofifo_rd    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s   = ST_ACC;
          tap_cnt_s = TAP_ZERO;
          out_idx_s = OUT_ZERO;
        end else begin
          state_s   = ST_IDLE;
        end
      end

      ST_ACC: begin
        // acc stays high through bubbles: dropping it mid-pixel would make
        // the SFU fire ReLU and wipe the partial sum. A bubble feeds zero.
        ofifo_rd = ofifo_valid;
        acc_s    = 1'b1;
        if (ofifo_valid) begin
          psum_s = ofifo_out;
          if (tap_cnt_r == TAP_LAST) begin
            tap_cnt_s = TAP_ZERO;
            state_s   = ST_RELU;
          end else begin
            tap_cnt_s = tap_cnt_r + TAP_ONE;
          end
        end else begin
          psum_s = W_ZERO;
        end
      end

      ST_RELU: begin
        // The final tap is still on psum_out/acc this cycle; the SFU adds it
        // at the closing edge. acc falls from the next cycle on.
        phase_s = 1'b0;
        state_s = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        if (!phase_r) begin
          // SFU registers ReLU(sum) at the end of this cycle.
          phase_s = 1'b1;
        end else begin
          // sfp_in holds the result for this cycle only; any later acc=0
          // cycle reloads the SFU output with ReLU(0).
          phase_s     = 1'b0;
          pmem_wr_s   = 1'b1;
          pmem_addr_s = out_idx_r;
          pmem_din_s  = sfp_in;
          if (out_idx_r == OUT_LAST) begin
            state_s = ST_DONE;
          end else begin
            out_idx_s = out_idx_r + OUT_ONE;
            tap_cnt_s = TAP_ZERO;
            state_s   = ST_ACC;
          end
        end
      end

      ST_DONE: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_r != ST_IDLE);

`ifdef SFU_FEEDER_STALL_CNT_EN
  // Saturating count of bubble cycles seen in ACC during the current run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'h0000;
    end else if ((state_r == ST_IDLE) && start) begin
      stall_cnt <= 16'h0000;
    end else if ((state_r == ST_ACC) && !ofifo_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_sfu_feeder.sv
// -----------------------------------------------------------------------------
// tb_sfu_feeder
//
// Two feeder instances share clock and reset: dut0 (num_acc=3, num_out=2) and
// dut1 (num_acc=1, num_out=4). Each is closed by a behavioural SFU (per-lane
// wrapping accumulator; acc=0 loads ReLU(sum) and clears). Expected pixel
// values come straight from the fed words: lane-wise 16-bit sum, then ReLU.
// Cycle expectations (pop enables, acc pattern, write and done timing) follow
// the protocol rules: ACC holds until num_acc pops, the write appears 4 cycles
// after the cycle holding the final pop, done one cycle after the last write.
// -----------------------------------------------------------------------------
module tb_sfu_feeder;

  localparam int W   = 128;
  localparam int NA0 = 3;
  localparam int NO0 = 2;
  localparam int NA1 = 1;
  localparam int NO1 = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start       [2];
  logic         ofifo_valid [2];
  logic [W-1:0] ofifo_out   [2];
  logic         ofifo_rd    [2];
  logic         acc         [2];
  logic [W-1:0] psum_out    [2];
  logic [W-1:0] sfp_in      [2];
  logic         pmem_wr     [2];
  logic [3:0]   pmem_addr   [2];
  logic [W-1:0] pmem_din    [2];
  logic         busy        [2];
  logic         done        [2];
`ifdef SFU_FEEDER_STALL_CNT_EN
  logic [15:0]  stall_cnt   [2];
`endif
  logic [W-1:0] sfu_sum     [2];

  int           tests_run    = 0;
  int           tests_failed = 0;
  logic [W-1:0] words  [$];
  logic [W-1:0] wr_log [$];

  always #5 clk = ~clk;

  sfu_feeder #(.psum_bw(16), .col(8), .num_acc(NA0), .num_out(NO0), .addr_bw(4)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .ofifo_valid(ofifo_valid[0]),
    .ofifo_out(ofifo_out[0]), .ofifo_rd(ofifo_rd[0]), .acc(acc[0]), .psum_out(psum_out[0]),
    .sfp_in(sfp_in[0]), .pmem_wr(pmem_wr[0]), .pmem_addr(pmem_addr[0]), .pmem_din(pmem_din[0]),
    .busy(busy[0]), .done(done[0])
`ifdef SFU_FEEDER_STALL_CNT_EN
    , .stall_cnt(stall_cnt[0])
`endif
  );

  sfu_feeder #(.psum_bw(16), .col(8), .num_acc(NA1), .num_out(NO1), .addr_bw(4)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .ofifo_valid(ofifo_valid[1]),
    .ofifo_out(ofifo_out[1]), .ofifo_rd(ofifo_rd[1]), .acc(acc[1]), .psum_out(psum_out[1]),
    .sfp_in(sfp_in[1]), .pmem_wr(pmem_wr[1]), .pmem_addr(pmem_addr[1]), .pmem_din(pmem_din[1]),
    .busy(busy[1]), .done(done[1])
`ifdef SFU_FEEDER_STALL_CNT_EN
    , .stall_cnt(stall_cnt[1])
`endif
  );

  function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int l = 0; l < 8; l++) r[l*16 +: 16] = a[l*16 +: 16] + b[l*16 +: 16];
    return r;
  endfunction

  function automatic logic [W-1:0] lane_relu(input logic [W-1:0] a);
    logic [W-1:0] r;
    for (int l = 0; l < 8; l++) r[l*16 +: 16] = a[l*16 + 15] ? 16'h0000 : a[l*16 +: 16];
    return r;
  endfunction

  function automatic logic [W-1:0] lane0(input int v);
    logic [W-1:0] r;
    r = '0;
    r[15:0] = 16'(v);
    return r;
  endfunction

  // Behavioural SFU for both instances.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int u = 0; u < 2; u++) begin
        sfu_sum[u] <= '0;
        sfp_in[u]  <= '0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (acc[u]) begin
          sfu_sum[u] <= lane_add(sfu_sum[u], psum_out[u]);
        end else begin
          sfp_in[u]  <= lane_relu(sfu_sum[u]);
          sfu_sum[u] <= '0;
        end
      end
    end
  end

  // Runs one feeder pass on instance u using the global 'words' list.
  task automatic drive(input int u, input int nacc, input int npix, input int bub_pct,
                       input int gap_at, input int gap_len, input bit restart, input int abort_pop);
    logic [W-1:0] fq [$];
    logic [W-1:0] exp_din [$];
    logic [W-1:0] s;
    logic [W-1:0] prev_word;
    logic [W-1:0] exp_psum;
    int p, pops, pix_pops, wr_due, done_due, gap_left, bubbles;
    bit in_acc, prev_in_acc, prev_valid, fin, v;
    fq = words;
    for (int q = 0; q < npix; q++) begin
      s = '0;
      for (int k = 0; k < nacc; k++) s = lane_add(s, words[q*nacc + k]);
      exp_din.push_back(lane_relu(s));
    end
    wr_log.delete();
    p = 0; pops = 0; pix_pops = 0; wr_due = -1; done_due = -1; gap_left = gap_len; bubbles = 0;
    in_acc = 1'b0; prev_in_acc = 1'b0; prev_valid = 1'b0; prev_word = '0; fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      tests_run++;
      if (acc[u] !== prev_in_acc) begin
        tests_failed++;
        $display("FAIL u%0d acc c%0d: got %b want %b", u, c, acc[u], prev_in_acc);
      end
      if (prev_in_acc) begin
        exp_psum = prev_valid ? prev_word : '0;
        tests_run++;
        if (psum_out[u] !== exp_psum) begin
          tests_failed++;
          $display("FAIL u%0d psum_out c%0d: got %h want %h", u, c, psum_out[u], exp_psum);
        end
      end
      tests_run++;
      if (pmem_wr[u] !== (c == wr_due)) begin
        tests_failed++;
        $display("FAIL u%0d pmem_wr c%0d: got %b want %b", u, c, pmem_wr[u], (c == wr_due));
      end
      if (c == wr_due) begin
        tests_run += 2;
        if (pmem_addr[u] !== 4'(p)) begin
          tests_failed++;
          $display("FAIL u%0d pmem_addr pix%0d: got %0d want %0d", u, p, pmem_addr[u], p);
        end
        if (pmem_din[u] !== exp_din[p]) begin
          tests_failed++;
          $display("FAIL u%0d pmem_din pix%0d: got %h want %h", u, p, pmem_din[u], exp_din[p]);
        end
        wr_log.push_back(pmem_din[u]);
        p++;
        if (p < npix) begin
          in_acc = 1'b1;
          pix_pops = 0;
        end else begin
          done_due = c + 1;
        end
      end
      tests_run++;
      if (done[u] !== (c == done_due)) begin
        tests_failed++;
        $display("FAIL u%0d done c%0d: got %b want %b", u, c, done[u], (c == done_due));
      end
      if (c == 1) begin
        in_acc = 1'b1;
        tests_run++;
        if (busy[u] !== 1'b1) begin
          tests_failed++;
          $display("FAIL u%0d busy after start: got %b want 1", u, busy[u]);
        end
      end
      if (c == done_due) begin
        fin = 1'b1;
        tests_run++;
        if (busy[u] !== 1'b0) begin
          tests_failed++;
          $display("FAIL u%0d busy at done: got %b want 0", u, busy[u]);
        end
      end
      start[u] = (c == 0) || (restart && in_acc && (c % 3 == 0));
      v = (fq.size() > 0);
      if (gap_at >= 0 && pops == gap_at && gap_left > 0) begin
        v = 1'b0;
        gap_left--;
      end else if ($urandom_range(0, 99) < bub_pct) begin
        v = 1'b0;
      end
      ofifo_valid[u] = v;
      ofifo_out[u]   = v ? fq[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      tests_run++;
      if (ofifo_rd[u] !== (in_acc && v)) begin
        tests_failed++;
        $display("FAIL u%0d ofifo_rd c%0d: got %b want %b", u, c, ofifo_rd[u], (in_acc && v));
      end
      if (in_acc && !v) bubbles++;
      prev_in_acc = in_acc;
      prev_valid  = v;
      prev_word   = ofifo_out[u];
      if (in_acc && v) begin
        void'(fq.pop_front());
        pops++;
        pix_pops++;
        if (pix_pops == nacc) begin
          in_acc = 1'b0;
          wr_due = c + 4;
        end
        if (abort_pop > 0 && pops == abort_pop) fin = 1'b1;
      end
    end
    tests_run++;
    if (!fin) begin
      tests_failed++;
      $display("FAIL u%0d run timeout: got %0d writes want %0d", u, p, npix);
    end
    if (abort_pop == 0) begin
      start[u] = 1'b0;
      ofifo_valid[u] = 1'b0;
      tests_run++;
      if (p != npix) begin
        tests_failed++;
        $display("FAIL u%0d write count: got %0d want %0d", u, p, npix);
      end
`ifdef SFU_FEEDER_STALL_CNT_EN
      tests_run++;
      if (stall_cnt[u] !== 16'(bubbles)) begin
        tests_failed++;
        $display("FAIL u%0d stall_cnt: got %0d want %0d", u, stall_cnt[u], bubbles);
      end
`endif
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0;
      ofifo_valid[u] = 1'b0;
      ofifo_out[u] = '0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      tests_run++;
      if ({acc[u], pmem_wr[u], done[u], busy[u], ofifo_rd[u]} !== 5'b0 ||
          psum_out[u] !== '0 || pmem_addr[u] !== 4'd0 || pmem_din[u] !== '0) begin
        tests_failed++;
        $display("FAIL u%0d reset state: got acc%b wr%b done%b busy%b addr%0d din%h want all zero",
                 u, acc[u], pmem_wr[u], done[u], busy[u], pmem_addr[u], pmem_din[u]);
      end
    end
    reset = 1'b1;
  endtask

  task automatic load_directed;
    words.delete();
    words.push_back(lane0(5));
    words.push_back(lane0(-2));
    words.push_back(lane0(4));
    words.push_back(lane0(-7));
    words.push_back(lane0(1));
    words.push_back(lane0(2));
  endtask

  task automatic test_basic;
    load_directed();
    drive(0, NA0, NO0, 0, -1, 0, 1'b0, 0);
    tests_run++;
    if (wr_log.size() != 2) begin
      tests_failed++;
      $display("FAIL basic writes: got %0d want 2", wr_log.size());
    end else begin
      tests_run += 2;
      if (wr_log[0] !== lane0(7)) begin
        tests_failed++;
        $display("FAIL basic pix0: got %h want %h", wr_log[0], lane0(7));
      end
      if (wr_log[1] !== lane0(0)) begin
        tests_failed++;
        $display("FAIL basic pix1: got %h want %h", wr_log[1], lane0(0));
      end
    end
  endtask

  task automatic test_bubbles;
    load_directed();
    drive(0, NA0, NO0, 0, 1, 2, 1'b0, 0);
    tests_run++;
    if (wr_log.size() != 2 || wr_log[0] !== lane0(7) || wr_log[1] !== lane0(0)) begin
      tests_failed++;
      $display("FAIL bubbles results: got %0d writes want 2 writes of 7 and 0", wr_log.size());
    end
`ifdef SFU_FEEDER_STALL_CNT_EN
    tests_run++;
    if (stall_cnt[0] !== 16'd2) begin
      tests_failed++;
      $display("FAIL bubbles stall_cnt: got %0d want 2", stall_cnt[0]);
    end
`endif
  endtask

  task automatic test_start_ignored;
    words.delete();
    for (int i = 0; i < NA0*NO0; i++) words.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
    drive(0, NA0, NO0, 20, -1, 0, 1'b1, 0);
  endtask

  task automatic test_reset_midrun;
    load_directed();
    drive(0, NA0, NO0, 0, -1, 0, 1'b0, 5);
    reset = 1'b0;
    #1;
    tests_run++;
    if ({acc[0], pmem_wr[0], done[0], busy[0], ofifo_rd[0]} !== 5'b0 ||
        psum_out[0] !== '0 || pmem_addr[0] !== 4'd0 || pmem_din[0] !== '0) begin
      tests_failed++;
      $display("FAIL midrun reset: got acc%b wr%b done%b busy%b rd%b din%h want all zero",
               acc[0], pmem_wr[0], done[0], busy[0], ofifo_rd[0], pmem_din[0]);
    end
    ofifo_valid[0] = 1'b0;
    start[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (pmem_wr[0] !== 1'b0 || busy[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset hold c%0d: got wr%b busy%b want 0 0", i, pmem_wr[0], busy[0]);
      end
    end
    reset = 1'b1;
    load_directed();
    drive(0, NA0, NO0, 0, -1, 0, 1'b0, 0);
  endtask

  task automatic test_nacc1_max;
    words.delete();
    for (int i = 0; i < NO1; i++) words.push_back({8{16'h7FFF}});
    drive(1, NA1, NO1, 0, -1, 0, 1'b0, 0);
    for (int i = 0; i < wr_log.size(); i++) begin
      tests_run++;
      if (wr_log[i] !== {8{16'h7FFF}}) begin
        tests_failed++;
        $display("FAIL nacc1 max pix%0d: got %h want %h", i, wr_log[i], {8{16'h7FFF}});
      end
    end
  endtask

  task automatic test_mixed_signs;
    int in_v  [8] = '{-1, 1, -32768, 32767, 0, 2, -3, 4};
    int out_v [8] = '{0, 1, 0, 32767, 0, 2, 0, 4};
    logic [W-1:0] wi, wo;
    for (int l = 0; l < 8; l++) begin
      wi[l*16 +: 16] = 16'(in_v[l]);
      wo[l*16 +: 16] = 16'(out_v[l]);
    end
    words.delete();
    for (int i = 0; i < NO1; i++) words.push_back(wi);
    drive(1, NA1, NO1, 0, -1, 0, 1'b0, 0);
    tests_run++;
    if (wr_log.size() != NO1) begin
      tests_failed++;
      $display("FAIL mixed writes: got %0d want %0d", wr_log.size(), NO1);
    end else begin
      for (int i = 0; i < NO1; i++) begin
        tests_run++;
        if (wr_log[i] !== wo) begin
          tests_failed++;
          $display("FAIL mixed pix%0d: got %h want %h", i, wr_log[i], wo);
        end
      end
    end
  endtask

  task automatic test_back_to_back_random;
    for (int r = 0; r < 6; r++) begin
      int u, na, no;
      u  = r % 2;
      na = (u == 0) ? NA0 : NA1;
      no = (u == 0) ? NO0 : NO1;
      words.delete();
      for (int i = 0; i < na*no; i++) words.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      drive(u, na, no, 30, -1, 0, 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_start_ignored();
    test_reset_midrun();
    test_nacc1_max();
    test_mixed_signs();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
